cp0_unit: RTL

//  Coprocessor-0 for the 5-stage MIPS core; the responder to the fetch stage's exception/eret interface.

---
 rtl/cp0_unit_pkg.sv | 63 ++++++
 rtl/cp0_unit_if.sv | 44 ++++
 rtl/cp0_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// -----------------------------------------------------------------------------
// cp0_unit_pkg
// Shared definitions for the coprocessor-0 block:
//   - CP0 register numbers (SR, Cause, EPC, PrID)
//   - exception code constants
//   - SR / Cause field bit positions
//   - exception handler entry address
//   - packed register layouts
//   - helper that computes the EPC value for a faulting instruction
// -----------------------------------------------------------------------------
package cp0_unit_pkg;

    // CP0 register numbers as seen by mfc0/mtc0
    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    // Exception codes carried down the pipe to M
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Field positions (LSB of each field) within SR and Cause
    localparam int SR_IE_BIT        = 0;
    localparam int SR_EXL_BIT       = 1;
    localparam int SR_IM_LSB        = 10;
    localparam int CAUSE_EXC_LSB    = 2;
    localparam int CAUSE_IP_LSB     = 10;
    localparam int CAUSE_BD_BIT     = 31;

    // Fetch redirect target when IntReq fires
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    // Only the implemented SR bits are stored
    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    // Only the implemented Cause bits are stored
    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    // Word-aligned restart address; a delay-slot fault restarts at the branch.
    // Subtraction wraps modulo 2^32 by construction.
    function automatic logic [31:0] exc_epc(input logic [29:0] pc_word, input logic bd);
        logic [31:0] aligned;
        aligned = {pc_word, 2'b00};
        if (bd) begin
            return aligned - 32'd4;
        end else begin
            return aligned;
        end
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// -----------------------------------------------------------------------------
// cp0_unit_if
// Bundle between the pipeline (master) and coprocessor 0 (slave).
//   A1        mfc0 source register number
//   A2        mtc0 destination register number
//   DIn       mtc0 write data
//   we        mtc0 write enable (M stage)
//   PC_M      PC of the instruction in M
//   BD_M      instruction in M sits in a branch delay slot
//   ExcCode_M exception code reaching M, 0 = none
//   HWInt     external level-sensitive interrupt lines
//   EXLClr    eret in M
//   IntReq    take exception/interrupt this cycle (to fetch)
//   EPC       current EPC value (fetch target on eret)
//   DOut      mfc0 read data
// -----------------------------------------------------------------------------
interface cp0_unit_if;

    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        we;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    // Pipeline side
    modport master (
        output A1, A2, DIn, we, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    // Coprocessor side
    modport slave (
        input  A1, A2, DIn, we, PC_M, BD_M, ExcCode_M, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );

endinterface

// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit
// Coprocessor 0 for the 5-stage MIPS core. Holds SR, Cause, EPC and PrID,
// decides at the M stage whether to take an interrupt or exception, and
// serves mfc0/mtc0.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    cp0_unit_if slave modport (see interface header for signals)
// IntReq and DOut are combinational from registered state plus M-stage inputs
// so fetch can redirect on the very next edge.
// -----------------------------------------------------------------------------
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h2020_1214,
    parameter logic [31:0] EPC_RST = 32'h0000_3000
) (
    input  logic         clk,
    input  logic         reset,
    cp0_unit_if.slave    bus
);

    sr_t         sr_q;
    sr_t         sr_d;
    cause_t      cause_q;
    cause_t      cause_d;
    logic [31:0] epc_q;
    logic [31:0] epc_d;

    logic        int_pend_s;
    logic        exc_pend_s;
    logic        int_req_s;
    logic [31:0] dout_s;
    logic        pc_low_unused_s;

    // Byte offset of PC_M never matters: EPC is always word aligned
    assign pc_low_unused_s = ^bus.PC_M[1:0];

    // Request evaluation; EXL blocks everything so handlers never nest
    always_comb begin
        int_pend_s = (|(bus.HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
        exc_pend_s = (bus.ExcCode_M != EXC_INT) & ~sr_q.exl;
        int_req_s  = int_pend_s | exc_pend_s;
    end

    // Next-state: taken request beats mtc0 and eret; mtc0 to SR then eret
    always_comb begin
        sr_d        = sr_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        // Pending-interrupt view tracks the lines regardless of masks
        cause_d.ip  = bus.HWInt;
        if (int_req_s) begin
            sr_d.exl         = 1'b1;
            cause_d.bd       = bus.BD_M;
            // Interrupt outranks a simultaneous exception
            if (int_pend_s) begin
                cause_d.exc_code = EXC_INT;
            end else begin
                cause_d.exc_code = bus.ExcCode_M;
            end
            epc_d            = exc_epc(bus.PC_M[31:2], bus.BD_M);
        end else begin
            if (bus.we) begin
                case (bus.A2)
                    CP0_REG_SR: begin
                        sr_d.im  = bus.DIn[SR_IM_LSB +: 6];
                        sr_d.exl = bus.DIn[SR_EXL_BIT];
                        sr_d.ie  = bus.DIn[SR_IE_BIT];
                    end
                    CP0_REG_EPC: begin
                        epc_d = {bus.DIn[31:2], 2'b00};
                    end
                    default: begin
                        // Cause, PrID and unimplemented numbers are read-only
                        epc_d = epc_q;
                    end
                endcase
            end else begin
                epc_d = epc_q;
            end
            // eret applied after any same-cycle SR write
            if (bus.EXLClr) begin
                sr_d.exl = 1'b0;
            end else begin
                sr_d.exl = sr_d.exl;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q    <= '{im: 6'd0, exl: 1'b0, ie: 1'b0};
            cause_q <= '{bd: 1'b0, ip: 6'd0, exc_code: 5'd0};
            epc_q   <= EPC_RST;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // mfc0 read mux over registered state only; unimplemented bits read 0
    always_comb begin
        dout_s = 32'h0000_0000;
        case (bus.A1)
            CP0_REG_SR: begin
                dout_s = {16'h0000, sr_q.im, 8'h00, sr_q.exl, sr_q.ie};
            end
            CP0_REG_CAUSE: begin
                dout_s = {cause_q.bd, 15'h0000, cause_q.ip, 3'b000,
                          cause_q.exc_code, 2'b00};
            end
            CP0_REG_EPC: begin
                dout_s = epc_q;
            end
            CP0_REG_PRID: begin
                dout_s = PRID;
            end
            default: begin
                dout_s = 32'h0000_0000;
            end
        endcase
    end

    assign bus.IntReq = int_req_s;
    assign bus.EPC    = epc_q;
    assign bus.DOut   = dout_s;

endmodule
